// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: owns the architectural fetch PC, presents fetch
// requests with valid/ready, and on an accepted mispredict redirect squashes
// the front end for FLUSH_CYCLES cycles before restarting fetch at the target.
// Every output is a flop, so nothing combinational reaches an output from
// flush_in. Release of rst_n is assumed already synchronised upstream.

package fetch_redirect_pkg;
  // sb = take the redirect target, pc_plus_4_t = keep fetching sequentially
  typedef enum logic {
    pc_plus_4_t = 1'b0,
    sb          = 1'b1
  } next_pc_t;
endpackage

module fetch_redirect_ctrl
  import fetch_redirect_pkg::*;
#(
  parameter int                         INST_ADDR_WIDTH = 32,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int                         FLUSH_CYCLES    = 2,
  parameter int                         CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_in,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc_in,
  input  next_pc_t                   next_pc_sel,
  input  logic                       fetch_ready,
  output logic                       fetch_valid,
  output logic [INST_ADDR_WIDTH-1:0] fetch_pc,
  output logic                       squash,
  output logic                       redirect_busy,
  output logic [CNT_WIDTH-1:0]       flush_count,
  output logic                       redirect_misaligned
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // 4 bits covers the whole legal 1..15 squash length
  localparam logic [3:0] CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t                     state;
  logic [3:0]                 cnt;
  logic [INST_ADDR_WIDTH-1:0] pc;
  logic [INST_ADDR_WIDTH-1:0] target;
  logic                       accept;
  logic                       handshake;
  logic                       misaligned_in;

  // A redirect only counts when the mispredict logic selects the target.
  assign accept        = flush_in && (next_pc_sel == sb);
  assign handshake     = fetch_valid && fetch_ready;
  assign misaligned_in = |redirect_pc_in[1:0];
  assign fetch_pc      = pc;

  // Run/flush sequencer; squash, busy and valid are registered with the state
  // so squash and fetch_valid can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pc            <= RESET_PC;
      target        <= '0;
      cnt           <= '0;
      fetch_valid   <= 1'b0;
      squash        <= 1'b0;
      redirect_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            // redirect wins over a same-cycle handshake: pc stays put
            state         <= FLUSH;
            target        <= {redirect_pc_in[INST_ADDR_WIDTH-1:2], 2'b00};
            cnt           <= CNT_RELOAD;
            fetch_valid   <= 1'b0;
            squash        <= 1'b1;
            redirect_busy <= 1'b1;
          end else begin
            fetch_valid <= 1'b1;
            if (handshake) pc <= pc + INST_ADDR_WIDTH'(4);
          end
        end
        FLUSH: begin
          if (accept) begin
            // newer redirect replaces the pending target and restarts the squash
            target <= {redirect_pc_in[INST_ADDR_WIDTH-1:2], 2'b00};
            cnt    <= CNT_RELOAD;
          end else if (cnt == 4'd0) begin
            state         <= RUN;
            pc            <= target;
            fetch_valid   <= 1'b1;
            squash        <= 1'b0;
            redirect_busy <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state         <= RUN;
          fetch_valid   <= 1'b0;
          squash        <= 1'b0;
          redirect_busy <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of accepted redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     flush_count <= '0;
    else if (accept && !(&flush_count)) flush_count <= flush_count + CNT_WIDTH'(1);
  end

  // One-cycle flag for a target whose low two bits were dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) redirect_misaligned <= 1'b0;
    else        redirect_misaligned <= accept && misaligned_in;
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model. A second instance with a 2-bit counter checks saturation.
module tb_fetch_redirect_ctrl;
  import fetch_redirect_pkg::*;

  localparam int          W   = 32;
  localparam logic [31:0] RPC = 32'h100;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  next_pc_t    next_pc_sel = pc_plus_4_t;
  logic        fetch_ready = 1'b0;

  logic        fetch_valid, squash, redirect_busy, redirect_misaligned;
  logic [31:0] fetch_pc;
  logic [15:0] flush_count;
  logic        d2_valid, d2_squash, d2_busy, d2_mis;
  logic [31:0] d2_pc;
  logic [1:0]  d2_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.INST_ADDR_WIDTH(W), .RESET_PC(RPC), .FLUSH_CYCLES(FC), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .redirect_pc_in(redirect_pc_in),
    .next_pc_sel(next_pc_sel), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .squash(squash), .redirect_busy(redirect_busy),
    .flush_count(flush_count), .redirect_misaligned(redirect_misaligned));

  fetch_redirect_ctrl #(.INST_ADDR_WIDTH(W), .RESET_PC(RPC), .FLUSH_CYCLES(FC), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .redirect_pc_in(redirect_pc_in),
    .next_pc_sel(next_pc_sel), .fetch_ready(fetch_ready), .fetch_valid(d2_valid),
    .fetch_pc(d2_pc), .squash(d2_squash), .redirect_busy(d2_busy),
    .flush_count(d2_count), .redirect_misaligned(d2_mis));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // squash_left = squash cycles still to be shown; the PC jumps to the pending
  // target as the last one ends. started is low only in the first cycle after
  // reset release, when no request is yet presented.
  logic [31:0] m_pc, m_tgt;
  int          m_left, m_cnt;
  logic        m_started, m_mis;
  logic        acc;
  assign acc = flush_in && (next_pc_sel == sb);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RPC; m_tgt <= '0; m_left <= 0; m_cnt <= 0; m_started <= 1'b0; m_mis <= 1'b0;
    end else begin
      m_started <= 1'b1;
      m_mis     <= acc && (redirect_pc_in[1:0] != 2'b00);
      if (acc) begin
        m_cnt  <= m_cnt + 1;
        m_left <= FC;
        m_tgt  <= redirect_pc_in & 32'hFFFF_FFFC;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_pc <= m_tgt;
      end else if (m_started && fetch_ready) begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic        e_valid;
    logic [31:0] e_cnt, e_cnt2;
    e_valid = m_started && (m_left == 0);
    e_cnt   = (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt);
    e_cnt2  = (m_cnt > 3) ? 32'd3 : 32'(m_cnt);
    chk("m_fetch_valid", {31'd0, fetch_valid}, {31'd0, e_valid});
    chk("m_fetch_pc", fetch_pc, m_pc);
    chk("m_squash", {31'd0, squash}, {31'd0, m_left != 0});
    chk("m_busy", {31'd0, redirect_busy}, {31'd0, m_left != 0});
    chk("m_flush_count", {16'd0, flush_count}, e_cnt);
    chk("m_misaligned", {31'd0, redirect_misaligned}, {31'd0, m_mis});
    chk("m_excl", {31'd0, squash && fetch_valid}, 32'd0);
    chk("m2_fetch_pc", d2_pc, m_pc);
    chk("m2_squash", {31'd0, d2_squash}, {31'd0, m_left != 0});
    chk("m2_flush_count", {30'd0, d2_count}, e_cnt2);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; flush_in = 1'b0; next_pc_sel = pc_plus_4_t; fetch_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic redirect(input logic [31:0] a);
    flush_in = 1'b1; next_pc_sel = sb; redirect_pc_in = a;
    tick();
    flush_in = 1'b0; next_pc_sel = pc_plus_4_t;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    bit seen;
    seen = 1'b0;
    redirect(a);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (fetch_valid) seen = 1'b1;
      else tick();
    end
    chk("goto_timeout", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values while held
    fetch_ready = 1'b1;
    tick();
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_squash", {31'd0, squash}, 32'd0);
    chk("rst_pc", fetch_pc, 32'h100);

    // sequential fetch after reset
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", fetch_pc, 32'h100 + 32'(4 * i));
      chk("seq_valid", {31'd0, fetch_valid}, 32'd1);
      tick();
    end
    chk("seq_count", {16'd0, flush_count}, 32'd0);

    // redirect at 0x200 beats a same-cycle handshake
    apply_reset();
    goto_pc(32'h200);
    chk("t2_at200", fetch_pc, 32'h200);
    fetch_ready = 1'b1;
    redirect(32'h1000);
    chk("t2_sq1", {31'd0, squash}, 32'd1);
    chk("t2_v1", {31'd0, fetch_valid}, 32'd0);
    tick();
    chk("t2_sq2", {31'd0, squash}, 32'd1);
    tick();
    chk("t2_sq3", {31'd0, squash}, 32'd0);
    chk("t2_pc", fetch_pc, 32'h1000);
    chk("t2_valid", {31'd0, fetch_valid}, 32'd1);
    chk("t2_count", {16'd0, flush_count}, 32'd2);

    // second redirect during the squash replaces the first target
    apply_reset();
    redirect(32'h1000);
    chk("t3_sq1", {31'd0, squash}, 32'd1);
    redirect(32'h2000);
    chk("t3_sq2", {31'd0, squash}, 32'd1);
    tick();
    chk("t3_sq3", {31'd0, squash}, 32'd1);
    tick();
    chk("t3_pc", fetch_pc, 32'h2000);
    chk("t3_valid", {31'd0, fetch_valid}, 32'd1);
    chk("t3_count", {16'd0, flush_count}, 32'd2);

    // sequential select ignores flush_in
    apply_reset();
    goto_pc(32'h40);
    flush_in = 1'b1; next_pc_sel = pc_plus_4_t; redirect_pc_in = 32'h8000; fetch_ready = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("t4_squash", {31'd0, squash}, 32'd0);
    chk("t4_pc", fetch_pc, 32'h44);
    chk("t4_count", {16'd0, flush_count}, 32'd1);

    // misaligned target
    apply_reset();
    redirect(32'h1003);
    chk("t5_mis1", {31'd0, redirect_misaligned}, 32'd1);
    tick();
    chk("t5_mis2", {31'd0, redirect_misaligned}, 32'd0);
    tick();
    chk("t5_pc", fetch_pc, 32'h1000);

    // stall and wrap
    apply_reset();
    goto_pc(32'hFFFF_FFFC);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold", fetch_pc, 32'hFFFF_FFFC);
    end
    fetch_ready = 1'b1;
    tick();
    chk("t6_wrap", fetch_pc, 32'h0);

    // reset in the middle of a squash
    apply_reset();
    redirect(32'h3000);
    chk("t7_sq", {31'd0, squash}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_sq_rst", {31'd0, squash}, 32'd0);
    chk("t7_busy_rst", {31'd0, redirect_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_pc", fetch_pc, 32'h100);
    chk("t7_valid", {31'd0, fetch_valid}, 32'd1);

    // counter saturation on the 2-bit instance
    apply_reset();
    flush_in = 1'b1; next_pc_sel = sb; redirect_pc_in = 32'h500;
    repeat (5) tick();
    flush_in = 1'b0;
    chk("t8_count16", {16'd0, flush_count}, 32'd5);
    chk("t8_count2", {30'd0, d2_count}, 32'd3);

    // randomized traffic, checked every cycle by the model
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      flush_in       = ($urandom_range(0, 6) == 0);
      next_pc_sel    = next_pc_t'($urandom_range(0, 1));
      redirect_pc_in = $urandom();
      fetch_ready    = ($urandom_range(0, 3) != 0);
      rst_n          = ($urandom_range(0, 400) != 0);
      tick();
    end
    rst_n = 1'b1; flush_in = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
